// File: rtl/twdl_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : twdl_seq_ctrl
// Brief    : Sequencer for the CORDIC twiddle generator. For a 2-D FFT split
//            N = N1*N2 it issues one (k1*n2, N) request per cycle in
//            n2-inner / k1-outer order, then delays the valid flag and the
//            (k1, n2) tags by the generator latency so they line up with the
//            generator output.
// Revision : 1.0 - initial release
// ============================================================================
module twdl_seq_ctrl #(
    parameter int wDataIn = 12,
    parameter int LAT     = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [wDataIn-1:0] cfg_n1,
    input  logic [wDataIn-1:0] cfg_n2,
    output logic               busy,
    output logic               cfg_err,
    output logic [wDataIn-1:0] tw_num,
    output logic [wDataIn-1:0] tw_den,
    output logic               tw_issue,
    output logic               out_valid,
    output logic [wDataIn-1:0] out_k1,
    output logic [wDataIn-1:0] out_n2,
    output logic               done
);

    localparam int             W     = wDataIn;
    localparam logic [W-1:0]   c_one = W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           busy_q, busy_d;
    logic           cfg_err_q, cfg_err_d;
    logic           issue_q, issue_d;
    logic           done_q, done_d;
    logic [W-1:0]   cfg_n1_q, cfg_n1_d;
    logic [W-1:0]   cfg_n2_q, cfg_n2_d;
    logic [W-1:0]   k1_q, k1_d;
    logic [W-1:0]   n2_idx_q, n2_idx_d;
    logic [W-1:0]   num_q, num_d;
    logic [W-1:0]   den_q, den_d;

    // Latency-matching delay line for valid and index tags
    logic [LAT-1:0] vld_sr_q, vld_sr_d;
    logic [W-1:0]   k1_sr_q [LAT];
    logic [W-1:0]   k1_sr_d [LAT];
    logic [W-1:0]   n2_sr_q [LAT];
    logic [W-1:0]   n2_sr_d [LAT];

    // Full-width product so an oversized N1*N2 cannot wrap into range
    logic [2*W-1:0] cfg_prod;
    logic           cfg_bad;
    logic           last_pair;
    logic           tail_last;

    assign cfg_prod  = {{W{1'b0}}, cfg_n1} * {{W{1'b0}}, cfg_n2};
    assign cfg_bad   = (cfg_n1 == '0) || (cfg_n2 == '0) || (|cfg_prod[2*W-1:W]);
    assign last_pair = (k1_q == cfg_n1_q - c_one) && (n2_idx_q == cfg_n2_q - c_one);
    // Stage LAT-2 holds the pair that reaches the output next cycle, so done
    // can be registered and still coincide with the last out_valid.
    assign tail_last = vld_sr_q[LAT-2]
                    && (k1_sr_q[LAT-2] == cfg_n1_q - c_one)
                    && (n2_sr_q[LAT-2] == cfg_n2_q - c_one);

    // Next-state logic: config check, incremental numerator walk, drain/done
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        cfg_err_d = 1'b0;
        issue_d   = 1'b0;
        done_d    = 1'b0;
        cfg_n1_d  = cfg_n1_q;
        cfg_n2_d  = cfg_n2_q;
        k1_d      = k1_q;
        n2_idx_d  = n2_idx_q;
        num_d     = num_q;
        den_d     = den_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        state_d  = S_RUN;
                        busy_d   = 1'b1;
                        cfg_n1_d = cfg_n1;
                        cfg_n2_d = cfg_n2;
                        den_d    = cfg_prod[W-1:0];
                        issue_d  = 1'b1;
                        k1_d     = '0;
                        n2_idx_d = '0;
                        num_d    = '0;
                    end
                end
            end
            S_RUN: begin
                if (last_pair) begin
                    state_d = S_DRAIN;
                end else begin
                    issue_d = 1'b1;
                    if (n2_idx_q == cfg_n2_q - c_one) begin
                        n2_idx_d = '0;
                        k1_d     = k1_q + c_one;
                        num_d    = '0;
                    end else begin
                        n2_idx_d = n2_idx_q + c_one;
                        // k1*n2 < N always, so the running sum never wraps
                        num_d    = num_q + k1_q;
                    end
                end
            end
            S_DRAIN: begin
                if (done_q) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else if (tail_last) begin
                    done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Shift the issued pair down the latency-matching delay line
    always_comb begin
        vld_sr_d   = {vld_sr_q[LAT-2:0], issue_q};
        k1_sr_d[0] = k1_q;
        n2_sr_d[0] = n2_idx_q;
        for (int i = 1; i < LAT; i++) begin
            k1_sr_d[i] = k1_sr_q[i-1];
            n2_sr_d[i] = n2_sr_q[i-1];
        end
    end

    // State and output registers; reset drops everything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            issue_q   <= 1'b0;
            done_q    <= 1'b0;
            cfg_n1_q  <= '0;
            cfg_n2_q  <= '0;
            k1_q      <= '0;
            n2_idx_q  <= '0;
            num_q     <= '0;
            den_q     <= '0;
            vld_sr_q  <= '0;
            k1_sr_q   <= '{default: '0};
            n2_sr_q   <= '{default: '0};
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            cfg_err_q <= cfg_err_d;
            issue_q   <= issue_d;
            done_q    <= done_d;
            cfg_n1_q  <= cfg_n1_d;
            cfg_n2_q  <= cfg_n2_d;
            k1_q      <= k1_d;
            n2_idx_q  <= n2_idx_d;
            num_q     <= num_d;
            den_q     <= den_d;
            vld_sr_q  <= vld_sr_d;
            k1_sr_q   <= k1_sr_d;
            n2_sr_q   <= n2_sr_d;
        end
    end

    assign busy      = busy_q;
    assign cfg_err   = cfg_err_q;
    assign tw_num    = num_q;
    assign tw_den    = den_q;
    assign tw_issue  = issue_q;
    assign out_valid = vld_sr_q[LAT-1];
    assign out_k1    = k1_sr_q[LAT-1];
    assign out_n2    = n2_sr_q[LAT-1];
    assign done      = done_q;

    // Numerator must always be a proper fraction of the denominator
    a_num_lt_den: assert property (@(posedge clk) disable iff (rst)
                                   issue_q |-> (num_q < den_q));

endmodule
`default_nettype wire

// File: tb/tb_twdl_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_twdl_seq_ctrl
// Brief    : Directed, table-driven bench for twdl_seq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_twdl_seq_ctrl;

    localparam int W   = 12;
    localparam int LAT = 24;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] cfg_n1;
    logic [W-1:0] cfg_n2;
    logic         busy;
    logic         cfg_err;
    logic [W-1:0] tw_num;
    logic [W-1:0] tw_den;
    logic         tw_issue;
    logic         out_valid;
    logic [W-1:0] out_k1;
    logic [W-1:0] out_n2;
    logic         done;

    twdl_seq_ctrl #(.wDataIn(W), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_n1    (cfg_n1),
        .cfg_n2    (cfg_n2),
        .busy      (busy),
        .cfg_err   (cfg_err),
        .tw_num    (tw_num),
        .tw_den    (tw_den),
        .tw_issue  (tw_issue),
        .out_valid (out_valid),
        .out_k1    (out_k1),
        .out_n2    (out_n2),
        .done      (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int n1;
        int n2;
        bit err;
        int ign1;   // cycle of an ignored start with cfg_n1=0 (0 = none)
        int ign2;   // cycle of an ignored start with a valid 3x3 cfg (0 = none)
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},      int'(busy), 0);
        chk({tag, "_cfg_err"},   int'(cfg_err), 0);
        chk({tag, "_tw_num"},    int'(tw_num), 0);
        chk({tag, "_tw_den"},    int'(tw_den), 0);
        chk({tag, "_tw_issue"},  int'(tw_issue), 0);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_k1"},    int'(out_k1), 0);
        chk({tag, "_out_n2"},    int'(out_n2), 0);
        chk({tag, "_done"},      int'(done), 0);
    endtask

    // Start a sequence on the next edge and check every cycle against the
    // expected schedule: issue t=1..N, out_valid t=LAT+1..N+LAT, done at
    // t=N+LAT, busy low at t=N+LAT+1. rst_at>0 asserts reset (with a
    // simultaneous start) at that cycle and checks the cleared state.
    task automatic run(input int n1, input int n2, input bit err,
                       input int ign1, input int ign2, input int rst_at);
        int nn;
        int i;
        nn     = n1 * n2;
        start  = 1'b1;
        cfg_n1 = n1[W-1:0];
        cfg_n2 = n2[W-1:0];
        if (err) begin
            @(negedge clk);
            start = 1'b0;
            chk("err_pulse",  int'(cfg_err), 1);
            chk("err_busy",   int'(busy), 0);
            chk("err_issue",  int'(tw_issue), 0);
            @(negedge clk);
            chk("err_clear",  int'(cfg_err), 0);
            chk("err_busy2",  int'(busy), 0);
            chk("err_issue2", int'(tw_issue), 0);
            return;
        end
        for (int t = 1; t <= nn + LAT + 1; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (rst_at != 0 && t == rst_at + 1) begin
                chk_all_zero("rst");
                rst = 1'b0;
                return;
            end
            chk("tw_issue",  int'(tw_issue),  int'(t <= nn));
            chk("busy",      int'(busy),      int'(t <= nn + LAT));
            chk("out_valid", int'(out_valid), int'(t > LAT && t <= nn + LAT));
            chk("done",      int'(done),      int'(t == nn + LAT));
            chk("cfg_err",   int'(cfg_err),   0);
            chk("tw_den",    int'(tw_den),    nn);
            if (t <= nn) begin
                i = t - 1;
                chk("tw_num", int'(tw_num), (i / n2) * (i % n2));
            end
            if (t > LAT && t <= nn + LAT) begin
                i = t - 1 - LAT;
                chk("out_k1", int'(out_k1), i / n2);
                chk("out_n2", int'(out_n2), i % n2);
            end
            if (t == ign1) begin
                start  = 1'b1;
                cfg_n1 = '0;
                cfg_n2 = W'(3);
            end
            if (t == ign2) begin
                start  = 1'b1;
                cfg_n1 = W'(3);
                cfg_n2 = W'(3);
            end
            if (rst_at != 0 && t == rst_at) begin
                rst    = 1'b1;
                start  = 1'b1;
                cfg_n1 = W'(2);
                cfg_n2 = W'(2);
            end
        end
    endtask

    initial begin
        vt[0]  = '{n1: 4,    n2: 4,  err: 1'b0, ign1: 5,   ign2: 40};
        vt[1]  = '{n1: 8,    n2: 64, err: 1'b0, ign1: 100, ign2: 530};
        vt[2]  = '{n1: 0,    n2: 5,  err: 1'b1, ign1: 0,   ign2: 0};
        vt[3]  = '{n1: 64,   n2: 65, err: 1'b1, ign1: 0,   ign2: 0};
        vt[4]  = '{n1: 1,    n2: 16, err: 1'b0, ign1: 0,   ign2: 20};
        vt[5]  = '{n1: 16,   n2: 1,  err: 1'b0, ign1: 3,   ign2: 0};
        vt[6]  = '{n1: 2,    n2: 2,  err: 1'b0, ign1: 0,   ign2: 0};
        vt[7]  = '{n1: 2,    n2: 2,  err: 1'b0, ign1: 0,   ign2: 0};
        vt[8]  = '{n1: 5,    n2: 0,  err: 1'b1, ign1: 0,   ign2: 0};
        vt[9]  = '{n1: 64,   n2: 64, err: 1'b1, ign1: 0,   ign2: 0};
        vt[10] = '{n1: 1,    n2: 1,  err: 1'b0, ign1: 0,   ign2: 0};
        vt[11] = '{n1: 4095, n2: 1,  err: 1'b0, ign1: 0,   ign2: 0};

        rst    = 1'b1;
        start  = 1'b0;
        cfg_n1 = '0;
        cfg_n2 = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // Table vectors run back to back: each start lands on the first
        // idle cycle after the previous sequence.
        for (int v = 0; v < 12; v++) begin
            run(vt[v].n1, vt[v].n2, vt[v].err, vt[v].ign1, vt[v].ign2, 0);
        end

        // Reset after five issues, with a start in the same cycle
        run(4, 4, 1'b0, 0, 0, 5);
        for (int c = 0; c < LAT + 16; c++) begin
            @(negedge clk);
            chk("post_rst_valid", int'(out_valid), 0);
            chk("post_rst_done",  int'(done), 0);
            chk("post_rst_busy",  int'(busy), 0);
            chk("post_rst_issue", int'(tw_issue), 0);
        end
        run(3, 3, 1'b0, 0, 0, 0);
        run(3, 5, 1'b0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
